hls_deadlock_monitor_param: RTL

Parametrised deadlock monitor for one dataflow process in the stereo-LBM HLS pipeline. It watches N AXI-Stream block indicators of the process's child channels and the idle flags of its sibling instances. It flags a deadlock only when a masked block condition persists for a programmable number of cycles while the dataflow region is not fully idle. It adds a sticky report, first-blocked channel index and a persistence counter for debug readback. With `THRESHOLD=1`, an all-ones mask and the idle input tied low, `block` behaves as the single-cycle registered monitor used today.

---
 rtl/hls_deadlock_pkg.sv | 22 ++
 rtl/hls_deadlock_prio_enc.sv | 25 ++
 rtl/hls_deadlock_monitor_param.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hls_deadlock_pkg.sv
// Shared types and defaults for the per-process HLS dataflow deadlock monitors.
package hls_deadlock_pkg;

  // Monitor FSM: no candidate / accumulating persistence / deadlock reported
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_THRESHOLD = 1;
  localparam int unsigned DEFAULT_CNT_W     = 16;

  // Ceiling log2 with a floor of 1 so a single-channel index still has a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    for (w = 1; (64'd1 << w) < 64'(n); w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder: reports the index of the lowest asserted input bit.
module hls_deadlock_prio_enc
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned N     = 7,
  parameter int unsigned IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one dataflow process: flags a masked stream block that
// persists THRESHOLD cycles while the region is not fully idle, with a sticky
// first-detection report and a saturating persistence counter for readback.
module hls_deadlock_monitor_param
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned N_AXIS    = 7,
  parameter int unsigned N_INST    = 41,
  parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W,
  parameter int unsigned IDX_W     = clog2_min1(N_AXIS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_AXIS-1:0] axis_block_mask,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_sticky,
  output logic [IDX_W-1:0]  block_idx,
  output logic [CNT_W-1:0]  block_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   THR_WIDE = (CNT_W + 1)'(THRESHOLD);
  localparam bit               ONE_SHOT = (THRESHOLD == 1);

  state_t           state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [CNT_W:0]   cnt_inc;
  logic             block_q, block_next;
  logic             sticky_q, sticky_next;
  logic [IDX_W-1:0] idx_q, idx_next;

  logic [N_AXIS-1:0] masked;
  logic              all_idle;
  logic              cand;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;

  // Block candidate: some participating channel stalled and region still busy
  always_comb begin
    masked   = axis_block_sigs & axis_block_mask;
    all_idle = &inst_idle_sigs;
    cand     = (|masked) & ~all_idle;
  end

  hls_deadlock_prio_enc #(
    .N     (N_AXIS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .in_vec (masked),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // Next-state, counter and sticky-report logic
  always_comb begin
    state_next  = state_q;
    cnt_next    = '0;
    sticky_next = sticky_q;
    idx_next    = idx_q;
    cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    if (cand) begin
      cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cand) begin
          state_next = ONE_SHOT ? BLOCKED : COUNT;
        end
      end
      COUNT: begin
        if (!cand) begin
          state_next = IDLE;
        end else if (cnt_inc >= THR_WIDE) begin
          state_next = BLOCKED;
        end
      end
      BLOCKED: begin
        if (!cand) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    block_next = (state_next == BLOCKED);

    // Clear beats a coincident detection; an unreported ongoing block re-arms
    if (clear) begin
      sticky_next = 1'b0;
      idx_next    = '0;
    end else if (!sticky_q && block_next && enc_valid) begin
      sticky_next = 1'b1;
      idx_next    = enc_idx;
    end
  end

  // State, counter and report registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      sticky_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_next;
      cnt_q    <= cnt_next;
      block_q  <= block_next;
      sticky_q <= sticky_next;
      idx_q    <= idx_next;
    end
  end

  assign block        = block_q;
  assign block_sticky = sticky_q;
  assign block_idx    = idx_q;
  assign block_cycles = cnt_q;

endmodule
